// File: rtl/alu_multiciclo.sv
// Registered MIPS-style ALU with iterative signed multiply/divide.
// Simple ops finish in one cycle; MULT/DIV take WIDTH iteration cycles.
module alu_multiciclo #(
    parameter int WIDTH   = 32,
    parameter int USA_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [3:0]       ALUcontrol,
    input  logic [WIDTH-1:0] entradaA,
    input  logic [WIDTH-1:0] entradaB,
    output logic [WIDTH-1:0] ALUsaida,
    output logic [WIDTH-1:0] saidaHI,
    output logic             Zero,
    output logic             overflow,
    output logic             erro_div0,
    output logic             ocupado,
    output logic             saida_valida
);

    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;
    localparam logic [SW-1:0] ULT = SW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {OCIOSO, S_MULT, S_DIV} estado_t;

    estado_t estado, prox;

    logic aceita, ultimo, vai_mult, vai_div;
    logic [SW-1:0] cnt;
    logic [SW-1:0] sh;
    logic [WIDTH-1:0] soma, dif;
    logic [WIDTH-1:0] r_lo, r_hi;
    logic r_ov, r_er;

    logic [WIDTH-1:0] mb, lo;
    logic [WIDTH:0] hi;
    logic neg, sa;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0] soma_m, desl, sub_d, nhi;
    logic [WIDTH-1:0] nlo;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0] f_lo, f_hi;

    assign sh   = entradaB[SW-1:0];
    assign soma = entradaA + entradaB;
    assign dif  = entradaA - entradaB;

    assign vai_mult = inicio && (ALUcontrol == OP_MULT);
    assign vai_div  = inicio && (ALUcontrol == OP_DIV)
                      && (USA_DIV != 0) && (entradaB != '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox;
    end

    // Next-state logic
    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO: begin
                if (vai_mult)     prox = S_MULT;
                else if (vai_div) prox = S_DIV;
            end
            S_MULT, S_DIV: if (ultimo) prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    // FSM outputs
    always_comb begin
        ocupado = (estado != OCIOSO);
        aceita  = (estado == OCIOSO) && inicio;
        ultimo  = ocupado && (cnt == ULT);
    end

    // Single-cycle results
    always_comb begin
        r_lo = '0;
        r_hi = '0;
        r_ov = 1'b0;
        r_er = 1'b0;
        case (ALUcontrol)
            OP_AND: r_lo = entradaA & entradaB;
            OP_OR:  r_lo = entradaA | entradaB;
            OP_NOR: r_lo = ~(entradaA | entradaB);
            OP_ADD: begin
                r_lo = soma;
                r_ov = (entradaA[M] == entradaB[M]) && (soma[M] != entradaA[M]);
            end
            OP_SUB: begin
                r_lo = dif;
                r_ov = (entradaA[M] != entradaB[M]) && (dif[M] != entradaA[M]);
            end
            OP_SLT: r_lo[0] = $signed(entradaA) < $signed(entradaB);
            OP_SLL: r_lo = entradaA << sh;
            OP_SRL: r_lo = entradaA >> sh;
            OP_SRA: r_lo = WIDTH'($signed(entradaA) >>> sh);
            OP_DIV: begin
                // Only reached here with a zero divisor
                if (USA_DIV != 0) begin
                    r_lo = '1;
                    r_hi = entradaA;
                    r_er = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mag_a = entradaA[M] ? -entradaA : entradaA;
    assign mag_b = entradaB[M] ? -entradaB : entradaB;

    // One shift-add / restoring-subtract step on magnitudes
    always_comb begin
        soma_m = hi + (lo[0] ? {1'b0, mb} : '0);
        desl   = {hi[WIDTH-1:0], lo[WIDTH-1]};
        sub_d  = desl - {1'b0, mb};
        if (estado == S_DIV) begin
            nhi = sub_d[WIDTH] ? desl : sub_d;
            nlo = {lo[WIDTH-2:0], ~sub_d[WIDTH]};
        end else begin
            nhi = {1'b0, soma_m[WIDTH:1]};
            nlo = {soma_m[0], lo[WIDTH-1:1]};
        end
        prod_mag = {nhi[WIDTH-1:0], nlo};
        prod     = neg ? -prod_mag : prod_mag;
        if (estado == S_DIV) begin
            f_lo = neg ? -nlo : nlo;
            f_hi = sa ? -nhi[WIDTH-1:0] : nhi[WIDTH-1:0];
        end else begin
            f_lo = prod[WIDTH-1:0];
            f_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUsaida     <= '0;
            saidaHI      <= '0;
            Zero         <= 1'b0;
            overflow     <= 1'b0;
            erro_div0    <= 1'b0;
            saida_valida <= 1'b0;
            mb           <= '0;
            hi           <= '0;
            lo           <= '0;
            neg          <= 1'b0;
            sa           <= 1'b0;
            cnt          <= '0;
        end else begin
            saida_valida <= 1'b0;
            if (aceita) begin
                if (vai_mult || vai_div) begin
                    mb  <= mag_b;
                    hi  <= '0;
                    lo  <= mag_a;
                    neg <= entradaA[M] ^ entradaB[M];
                    sa  <= entradaA[M];
                    cnt <= '0;
                end else begin
                    ALUsaida     <= r_lo;
                    saidaHI      <= r_hi;
                    Zero         <= (r_lo == '0);
                    overflow     <= r_ov;
                    erro_div0    <= r_er;
                    saida_valida <= 1'b1;
                end
            end else if (ocupado) begin
                hi  <= nhi;
                lo  <= nlo;
                cnt <= cnt + 1'b1;
                if (ultimo) begin
                    ALUsaida     <= f_lo;
                    saidaHI      <= f_hi;
                    Zero         <= (f_lo == '0);
                    overflow     <= 1'b0;
                    erro_div0    <= 1'b0;
                    saida_valida <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Random and directed bench for alu_multiciclo against an
// arithmetic reference model with per-cycle output checking.
module tb_alu_multiciclo;

    logic        clk;
    logic        rst_n;
    logic        inicio;
    logic [3:0]  ALUcontrol;
    logic [31:0] entradaA, entradaB;
    logic [31:0] ALUsaida, saidaHI;
    logic        Zero, overflow, erro_div0, ocupado, saida_valida;

    int total = 0;
    int bad   = 0;

    alu_multiciclo #(.WIDTH(32), .USA_DIV(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inicio(inicio),
        .ALUcontrol(ALUcontrol),
        .entradaA(entradaA),
        .entradaB(entradaB),
        .ALUsaida(ALUsaida),
        .saidaHI(saidaHI),
        .Zero(Zero),
        .overflow(overflow),
        .erro_div0(erro_div0),
        .ocupado(ocupado),
        .saida_valida(saida_valida)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] g,
                       input logic [63:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, g, e, $time);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers
    function automatic void modelo(
        input  logic [3:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] lo,
        output logic [31:0] hi,
        output logic        ov,
        output logic        er,
        output int          lat
    );
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t;
        longint r;
        lo = '0; hi = '0; ov = 0; er = 0; lat = 1;
        case (op)
            4'b0000: lo = a & b;
            4'b0001: lo = a | b;
            4'b1100: lo = ~(a | b);
            4'b0010: begin
                t = sa + sb; lo = t[31:0];
                ov = (t != longint'($signed(t[31:0])));
            end
            4'b0110: begin
                t = sa - sb; lo = t[31:0];
                ov = (t != longint'($signed(t[31:0])));
            end
            4'b0111: lo = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: lo = a << b[4:0];
            4'b0100: lo = a >> b[4:0];
            4'b0101: lo = $signed(a) >>> b[4:0];
            4'b1000: begin
                t = sa * sb;
                lo = t[31:0]; hi = t[63:32]; lat = 33;
            end
            4'b1001: begin
                if (b == 0) begin
                    lo = '1; hi = a; er = 1;
                end else begin
                    t = sa / sb; r = sa % sb;
                    lo = t[31:0]; hi = r[31:0]; lat = 33;
                end
            end
            default: ;
        endcase
    endfunction

    // Model state for the per-cycle compare
    logic        tem = 0;
    logic        longa = 0;
    int          due = 0;
    logic [31:0] e_lo, e_hi;
    logic        e_ov, e_er;
    int          e_lat;
    logic [31:0] l_lo = 0, l_hi = 0;
    logic        l_z = 0, l_ov = 0, l_er = 0;
    logic        vexp, oexp;

    always @(negedge clk) begin
        if (!rst_n) begin
            tem = 0;
            l_lo = 0; l_hi = 0; l_z = 0; l_ov = 0; l_er = 0;
            chk("rst_valida", 64'(saida_valida), 64'(0));
            chk("rst_ocupado", 64'(ocupado), 64'(0));
            chk("rst_lo", 64'(ALUsaida), 64'(0));
            chk("rst_hi", 64'(saidaHI), 64'(0));
            chk("rst_flags", 64'({Zero, overflow, erro_div0}), 64'(0));
        end else begin
            if (tem) due--;
            vexp = tem && (due == 0);
            oexp = tem && longa && (due > 0);
            if (vexp) begin
                l_lo = e_lo; l_hi = e_hi; l_ov = e_ov; l_er = e_er;
                l_z = (e_lo == 0);
                tem = 0;
            end
            chk("valida", 64'(saida_valida), 64'(vexp));
            chk("ocupado", 64'(ocupado), 64'(oexp));
            chk("lo", 64'(ALUsaida), 64'(l_lo));
            chk("hi", 64'(saidaHI), 64'(l_hi));
            chk("zero", 64'(Zero), 64'(l_z));
            chk("overflow", 64'(overflow), 64'(l_ov));
            chk("erro_div0", 64'(erro_div0), 64'(l_er));
            if (inicio && !oexp) begin
                modelo(ALUcontrol, entradaA, entradaB,
                       e_lo, e_hi, e_ov, e_er, e_lat);
                tem = 1;
                due = e_lat;
                longa = (e_lat > 1);
            end
        end
    end

    task automatic ciclo(input logic i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        inicio = i; ALUcontrol = op; entradaA = a; entradaB = b;
        @(posedge clk);
        #1;
        inicio = 0;
    endtask

    task automatic ocioso(input int n);
        repeat (n) ciclo(0, 4'b0010, $urandom, $urandom);
    endtask

    function automatic logic [31:0] rv();
        logic [31:0] v;
        case ($urandom % 8)
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = $urandom % 16;
            6: begin v = $urandom % 16; v = -v; end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    logic [31:0] m_lo, m_hi;
    logic        m_ov, m_er;
    int          m_lat;

    initial begin
        clk = 0; rst_n = 1; inicio = 0;
        ALUcontrol = 0; entradaA = 0; entradaB = 0;

        modelo(4'b0010, 32'h7FFF_FFFF, 32'h1, m_lo, m_hi, m_ov, m_er, m_lat);
        chk("pin_add", {m_lo, 31'd0, m_ov}, {32'h8000_0000, 32'h1});
        chk("pin_add_lat", 64'(m_lat), 64'(1));
        modelo(4'b1000, 32'hFFFF_FFFD, 32'd5, m_lo, m_hi, m_ov, m_er, m_lat);
        chk("pin_mult", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("pin_mult_lat", 64'(m_lat), 64'(33));
        modelo(4'b1001, 32'hFFFF_FFF9, 32'd2, m_lo, m_hi, m_ov, m_er, m_lat);
        chk("pin_div", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        modelo(4'b1001, 32'd9, 32'd0, m_lo, m_hi, m_ov, m_er, m_lat);
        chk("pin_div0", {m_hi, m_lo}, 64'h0000_0009_FFFF_FFFF);
        chk("pin_div0_f", {31'd0, m_er, 32'(m_lat)}, {32'd1, 32'd1});
        modelo(4'b1001, 32'h8000_0000, 32'hFFFF_FFFF,
               m_lo, m_hi, m_ov, m_er, m_lat);
        chk("pin_divmin", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
        modelo(4'b0101, 32'h8000_0000, 32'd4, m_lo, m_hi, m_ov, m_er, m_lat);
        chk("pin_sra", 64'(m_lo), 64'hF800_0000);
        modelo(4'b0111, 32'hFFFF_FFFB, 32'd3, m_lo, m_hi, m_ov, m_er, m_lat);
        chk("pin_slt", 64'(m_lo), 64'd1);

        #1 rst_n = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        ocioso(2);

        ciclo(1, 4'b0010, 32'h7FFF_FFFF, 32'h1);
        ocioso(2);
        ciclo(1, 4'b0111, 32'hFFFF_FFFB, 32'd3);
        ciclo(1, 4'b0110, 32'd7, 32'd7);
        ocioso(1);

        ciclo(1, 4'b1000, 32'hFFFF_FFFD, 32'd5);
        for (int i = 0; i < 32; i++)
            ciclo(i[0], 4'b0000, $urandom, $urandom);
        ciclo(1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        ocioso(2);

        ciclo(1, 4'b1001, 32'hFFFF_FFF9, 32'd2);
        ocioso(34);
        ciclo(1, 4'b1001, 32'd9, 32'd0);
        ocioso(1);
        ciclo(1, 4'b1001, 32'h8000_0000, 32'hFFFF_FFFF);
        ocioso(34);

        ciclo(1, 4'b1001, 32'd100, 32'd7);
        ocioso(9);
        rst_n = 0;
        ocioso(2);
        rst_n = 1;
        ocioso(2);
        ciclo(1, 4'b0101, 32'h8000_0000, 32'd4);
        ciclo(1, 4'b0101, 32'h8000_0000, 32'd0);
        ocioso(1);

        repeat (3000)
            ciclo(($urandom % 2) == 1, 4'($urandom % 16), rv(), rv());
        ocioso(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
